// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point datapath: default geometry,
// encoder FSM state codes and exponent helpers reused by downstream stages.
package bfp_pkg;

    localparam int BFP_EXP_SIZE   = 5;
    localparam int BFP_MANT_SIZE  = 10;
    localparam int BFP_BLOCK_SIZE = 4;

    // A BFP word is {sign, fraction}; a block packs BLOCK_SIZE words.
    localparam int BFP_WORD_W  = BFP_MANT_SIZE + 1;
    localparam int BFP_BLOCK_W = BFP_BLOCK_SIZE * BFP_WORD_W;

    typedef logic [1:0] bfp_state_t;

    localparam bfp_state_t ST_COLLECT = 2'd0;
    localparam bfp_state_t ST_ALIGN   = 2'd1;
    localparam bfp_state_t ST_OUT     = 2'd2;

    function automatic int bfp_bias(input int exp_size);
        return (1 << (exp_size - 1)) - 1;
    endfunction

    // Zero/subnormal fields behave as exponent 1 with no hidden bit.
    function automatic int unsigned bfp_eff_exp(input int unsigned exp_field);
        return (exp_field == 0) ? 32'd1 : exp_field;
    endfunction

    function automatic logic bfp_hidden_bit(input int unsigned exp_field);
        return (exp_field != 0);
    endfunction

endpackage

// File: rtl/bfp_align_shifter.sv
// Aligns one pre-shift fraction to the block exponent; the sign always passes
// through, and shifts of MANT_SIZE or more flush the fraction to zero.
module bfp_align_shifter
    import bfp_pkg::*;
#(
    parameter int EXP_SIZE  = BFP_EXP_SIZE,
    parameter int MANT_SIZE = BFP_MANT_SIZE
) (
    input  logic                 sign,
    input  logic [MANT_SIZE-1:0] frac,
    input  logic [EXP_SIZE-1:0]  shift,
    output logic [MANT_SIZE:0]   aligned
);

    always_comb begin
        aligned            = '0;
        aligned[MANT_SIZE] = sign;
        if (32'(shift) < MANT_SIZE) begin
            aligned[MANT_SIZE-1:0] = frac >> shift;
        end
    end

endmodule

// File: rtl/bfp_block_encoder.sv
// Collects BLOCK_SIZE scalar floats, finds the block's maximum exponent, aligns
// one mantissa per cycle and holds the finished block on a valid/ready output.
module bfp_block_encoder
    import bfp_pkg::*;
#(
    parameter int EXP_SIZE   = BFP_EXP_SIZE,
    parameter int MANT_SIZE  = BFP_MANT_SIZE,
    parameter int BLOCK_SIZE = BFP_BLOCK_SIZE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [EXP_SIZE+MANT_SIZE:0]         in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [BLOCK_SIZE*(MANT_SIZE+1)-1:0] out_data,
    output logic [EXP_SIZE-1:0]                 out_exp,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int WORD_W = MANT_SIZE + 1;
    localparam int IN_W   = 1 + EXP_SIZE + MANT_SIZE;
    localparam int CNT_W  = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and out_valid stays up until taken.

    bfp_state_t                     state;
    logic [CNT_W-1:0]               cnt;
    logic [EXP_SIZE-1:0]            max_exp;
    logic [BLOCK_SIZE-1:0]          sign_buf;
    logic [EXP_SIZE-1:0]            exp_buf  [BLOCK_SIZE];
    logic [MANT_SIZE-1:0]           frac_buf [BLOCK_SIZE];
    logic [BLOCK_SIZE*WORD_W-1:0]   data_r;
    logic [EXP_SIZE-1:0]            exp_r;

    logic                           in_sign;
    logic [EXP_SIZE-1:0]            in_exp_field;
    logic [EXP_SIZE-1:0]            in_eff_exp;
    logic [MANT_SIZE-1:0]           in_frac;
    logic                           in_fire;
    logic                           out_fire;
    logic [EXP_SIZE-1:0]            align_shift;
    logic [WORD_W-1:0]              align_word;

    assign in_sign      = in_data[IN_W-1];
    assign in_exp_field = in_data[MANT_SIZE +: EXP_SIZE];
    assign in_eff_exp   = EXP_SIZE'(bfp_eff_exp(32'(in_exp_field)));
    // The mantissa LSB is dropped to make room for the hidden bit.
    assign in_frac      = {bfp_hidden_bit(32'(in_exp_field)), in_data[MANT_SIZE-1:1]};

    assign in_ready  = (state == ST_COLLECT);
    assign out_valid = (state == ST_OUT);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = data_r;
    assign out_exp   = exp_r;

    assign align_shift = max_exp - exp_buf[cnt];

    bfp_align_shifter #(
        .EXP_SIZE  (EXP_SIZE),
        .MANT_SIZE (MANT_SIZE)
    ) u_align_shifter (
        .sign    (sign_buf[cnt]),
        .frac    (frac_buf[cnt]),
        .shift   (align_shift),
        .aligned (align_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_COLLECT;
            cnt      <= '0;
            max_exp  <= '0;
            sign_buf <= '0;
            data_r   <= '0;
            exp_r    <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                exp_buf[i]  <= '0;
                frac_buf[i] <= '0;
            end
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (in_fire) begin
                        sign_buf[cnt] <= in_sign;
                        exp_buf[cnt]  <= in_eff_exp;
                        frac_buf[cnt] <= in_frac;
                        if (in_eff_exp > max_exp) begin
                            max_exp <= in_eff_exp;
                        end
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= ST_ALIGN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_ALIGN: begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            data_r[i*WORD_W +: WORD_W] <= align_word;
                        end
                    end
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        exp_r <= max_exp;
                        state <= ST_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    // Clearing max_exp here keeps blocks independent.
                    if (out_fire) begin
                        max_exp <= '0;
                        state   <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
